// File: rtl/key_reset_pkg.sv
// Shared constants for the key/reset front-end: FSM encoding and the default timing for the
// 10 MHz build.
package key_reset_pkg;

  localparam logic [1:0] ST_PULSE = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    StPulse = ST_PULSE,
    StRun   = ST_RUN,
    StHold  = ST_HOLD
  } state_e;

  // 1 ms debounce and 6.4 us reset pulse at 10 MHz
  localparam int unsigned DefSyncStages     = 2;
  localparam int unsigned DefDebounceCycles = 10000;
  localparam int unsigned DefPulseCycles    = 64;
  localparam int unsigned DefCountWidth     = 8;

endpackage

// File: rtl/key_reset_sequencer_if.sv
// Button input and reset/status outputs of the key reset sequencer, bundled for port connection.
interface key_reset_sequencer_if
  import key_reset_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = DefCountWidth
);

  logic                   key_n;
  logic                   soc_reset;
  logic                   key_state;
  logic                   key_press;
  logic [COUNT_WIDTH-1:0] rst_count;

  modport master (
    output key_n,
    input  soc_reset,
    input  key_state,
    input  key_press,
    input  rst_count
  );

  modport slave (
    input  key_n,
    output soc_reset,
    output key_state,
    output key_press,
    output rst_count
  );

endinterface

// File: rtl/key_reset_sequencer_debounce.sv
// Synchroniser plus debounce for the raw active-low push-button; emits the debounced level and
// a one-cycle press strobe.
module key_debounce
  import key_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic key_state,
  output logic key_press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   press_q, press_d;
  logic                   s;

  // Flops reset to the released level so a held button is seen as a fresh press after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
    end
  end

  always_comb begin
    s       = ~sync_q[SYNC_STAGES-1];
    cnt_d   = '0;
    state_d = state_q;
    press_d = 1'b0;
    if (s != state_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        state_d = s;
        press_d = s;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
    end
  end

  assign key_state = state_q;
  assign key_press = press_q;

endmodule

// File: rtl/key_reset_sequencer.sv
// SoC reset front-end: stretches power-on and button-release resets, holds reset while the
// debounced button is down and counts button-initiated resets.
module key_reset_sequencer
  import key_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned PULSE_CYCLES    = DefPulseCycles,
  parameter int unsigned COUNT_WIDTH     = DefCountWidth
) (
  input logic            clk,
  input logic            reset_n,
  key_reset_sequencer_if.slave bus
);

  localparam int unsigned PulseW = $clog2(PULSE_CYCLES + 1);

  logic                   key_state;
  logic                   key_press;
  state_e                 state_q, state_d;
  logic [PulseW-1:0]      pulse_q, pulse_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   soc_reset_q, soc_reset_d;

  key_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_n     (bus.key_n),
    .key_state (key_state),
    .key_press (key_press)
  );

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    count_d = count_q;
    unique case (state_q)
      StPulse: begin
        // A press restarts everything, even on the last pulse cycle
        if (key_press) begin
          state_d = StHold;
          pulse_d = '0;
        end else if (pulse_q == PulseW'(PULSE_CYCLES - 1)) begin
          state_d = StRun;
          pulse_d = '0;
        end else begin
          pulse_d = pulse_q + PulseW'(1);
        end
      end
      StRun: begin
        if (key_press) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!key_state) begin
          state_d = StPulse;
          pulse_d = '0;
        end
      end
      default: begin
        state_d = StPulse;
        pulse_d = '0;
      end
    endcase
    if (state_d == StHold && state_q != StHold && count_q != '1) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
    soc_reset_d = (state_d != StRun);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StPulse;
      pulse_q     <= '0;
      count_q     <= '0;
      soc_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      count_q     <= count_d;
      soc_reset_q <= soc_reset_d;
    end
  end

  assign bus.soc_reset = soc_reset_q;
  assign bus.key_state = key_state;
  assign bus.key_press = key_press;
  assign bus.rst_count = count_q;

endmodule
